rcn_testregs_mc: RTL
====================

RCN_TESTREGS_MC -- requirements
Module: rcn_testregs_mc

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 24'hFFFF80, byte base of the register window; bits [6:0] SHALL be zero.
REQ-002 SHALL have parameter NUM_CH, default 4, number of test channels, legal range 1..8.
REQ-003 SHALL have parameter WDOG_W, default 24, width of the watchdog counter and limit.
REQ-004 clk  input  1  single clock; all state rises on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 rcn_in  input  69  ring input: [68] valid, [67] pending, [66] wr, [65:60] id, [59:56] mask, [55:34] addr[23:2], [33:32] seq, [31:0] data.
REQ-007 rcn_out  output  69  registered ring output, same format.
REQ-008 test_progress  output  32*NUM_CH  per-channel progress registers, channel 0 in the low bits.
REQ-009 test_fail  output  32*NUM_CH  per-channel fail registers.
REQ-010 test_pass  output  32*NUM_CH  per-channel pass registers.
REQ-011 test_done  output  NUM_CH  bit n set when channel n pass or fail is nonzero.
REQ-012 test_timeout  output  1  watchdog expiry flag.

Function
REQ-013 Hit: valid & pending & (addr[23:7] == ADDR_BASE[23:7]); all other flits SHALL be copied to rcn_out unchanged one cycle later.
REQ-014 Hit SHALL be consumed and replaced on rcn_out next cycle by a response: valid=1, pending=0, wr, id, mask, addr and seq unchanged, data = read value (read) or the received write data (write).
REQ-015 Register map: offset = ch*16 + {0 progress, 4 fail, 8 pass, 12 status}; ch = addr[6:4].
REQ-016 Status reads {29'b0, timeout, done[ch], wdog_armed}; writes to status SHALL be ignored, except that a write with data[2]=1 to channel 0 status SHALL clear test_timeout.
REQ-017 Writes SHALL update only the bytes with mask bits set.
REQ-018 Accesses to channels >= NUM_CH SHALL read 0, ignore writes, and still be answered.
REQ-019 Read-to-response latency SHALL be exactly 1 cycle; back-to-back hits every cycle SHALL each be answered in order.
REQ-020 A write and a read of the same register in consecutive cycles: the read SHALL return the newly written value.

Reset
REQ-021 On rst_n low: rcn_out = 0, all progress/fail/pass = 0, test_done = 0, test_timeout = 0, watchdog counter = 0, wdog_armed = 0.
REQ-022 Reset asserted mid-flit SHALL drop that flit; no response SHALL be emitted after release for a flit that arrived before or during reset.

Configuration
REQ-023 Macro RCN_TESTREGS_WDOG_EN compiles in the watchdog: wdog_armed is set by any progress write; the counter resets to 0 on every progress write and increments every cycle while armed and saturates at all-ones; test_timeout sets when counter == {WDOG_W{1}} and stays set until cleared per REQ-016 (clear also disarms and zeroes the counter); clear and expiry in the same cycle: clear wins.
REQ-024 Without RCN_TESTREGS_WDOG_EN: no counter exists, test_timeout is tied 0, and status bits [2] and [0] read 0.

Structure
REQ-025 Ring field offsets/widths and register offsets SHALL be localparams in a shared rcn_pkg package used by all rcn nodes.
REQ-026 One sub-module rcn_testregs_ch (one channel's three registers, byte-masked write, done logic) SHALL be instantiated NUM_CH times via generate.

Verification
REQ-027 Write 0x12345678 mask 4'hF to ADDR_BASE+0x10 -> next cycle response pending=0, same id/seq; test_progress[63:32] = 0x12345678.
REQ-028 Write 0xAABBCCDD mask 4'h3 to fail of ch2, then read it -> read returns 0x0000CCDD, test_done[2]=1.
REQ-029 Non-matching flit addr 24'h0E0000 -> emerges on rcn_out unchanged after exactly 1 cycle.
REQ-030 NUM_CH=2, read ADDR_BASE+0x30 -> response data 0; write there -> no output change.
REQ-031 WDOG_EN, WDOG_W=4: one progress write, idle 15 cycles -> test_timeout=1; write status data 0x4 -> test_timeout=0 next cycle.
REQ-032 Drop rst_n for 1 cycle during streaming hits -> all outputs 0, no stray response afterwards.

Source files
------------

// File: rtl/rcn_pkg.sv
// rcn_pkg: ring flit field layout, test-register offsets and byte-merge helper shared by rcn nodes
package rcn_pkg;
    localparam int RCN_W        = 69;
    localparam int RCN_VALID    = 68;
    localparam int RCN_PEND     = 67;
    localparam int RCN_WR       = 66;
    localparam int RCN_MASK_LSB = 56;
    localparam int RCN_ADDR_LSB = 34;
    localparam int RCN_ADDR_W   = 22;
    localparam int RCN_SEQ_LSB  = 32;

    localparam logic [3:0] OFF_PROGRESS = 4'h0;
    localparam logic [3:0] OFF_FAIL     = 4'h4;
    localparam logic [3:0] OFF_PASS     = 4'h8;
    localparam logic [3:0] OFF_STATUS   = 4'hC;

    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] data,
                                               input logic [3:0] mask);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = mask[i] ? data[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/rcn_testregs_ch.sv
// rcn_testregs_ch: one test channel's progress/fail/pass registers with byte-masked writes
//   clk, rst_n                        clock, async active-low reset
//   we_progress, we_fail, we_pass     register write strobes
//   mask, wdata                       byte enables and write data
//   progress, fail, pass              register contents
//   done                              fail or pass is nonzero
module rcn_testregs_ch
    import rcn_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_progress,
    input  logic        we_fail,
    input  logic        we_pass,
    input  logic [3:0]  mask,
    input  logic [31:0] wdata,
    output logic [31:0] progress,
    output logic [31:0] fail,
    output logic [31:0] pass,
    output logic        done
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            progress <= '0;
            fail     <= '0;
            pass     <= '0;
        end else begin
            if (we_progress) progress <= byte_merge(progress, wdata, mask);
            if (we_fail) fail <= byte_merge(fail, wdata, mask);
            if (we_pass) pass <= byte_merge(pass, wdata, mask);
        end

    assign done = |fail | |pass;
endmodule

// File: rtl/rcn_testregs_mc.sv
// rcn_testregs_mc: ring-attached bank of per-channel test progress/fail/pass registers with optional watchdog
//   clk, rst_n        clock, async active-low reset
//   rcn_in, rcn_out   ring flit in, registered ring flit out
//   test_progress     per-channel progress registers (channel 0 in low bits)
//   test_fail         per-channel fail registers
//   test_pass         per-channel pass registers
//   test_done         per-channel fail|pass nonzero
//   test_timeout      watchdog expiry flag
// Macro RCN_TESTREGS_WDOG_EN compiles in the progress watchdog.
module rcn_testregs_mc
    import rcn_pkg::*;
#(
    parameter logic [23:0] ADDR_BASE = 24'hFFFF80,
    parameter int          NUM_CH    = 4,
    parameter int          WDOG_W    = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [RCN_W-1:0]      rcn_in,
    output logic [RCN_W-1:0]      rcn_out,
    output logic [32*NUM_CH-1:0]  test_progress,
    output logic [32*NUM_CH-1:0]  test_fail,
    output logic [32*NUM_CH-1:0]  test_pass,
    output logic [NUM_CH-1:0]     test_done,
    output logic                  test_timeout
);
    logic [RCN_ADDR_W-1:0] addr;
    logic [31:0] wdata, rdata;
    logic [3:0]  mask, reg_off;
    logic [2:0]  ch;
    logic        hit, wr, we, ch_ok, armed, timeout;
    logic [31:0] prog8 [8];
    logic [31:0] fail8 [8];
    logic [31:0] pass8 [8];
    logic [7:0]  done8;

    assign addr    = rcn_in[RCN_ADDR_LSB +: RCN_ADDR_W];
    assign wdata   = rcn_in[31:0];
    assign mask    = rcn_in[RCN_MASK_LSB +: 4];
    assign wr      = rcn_in[RCN_WR];
    assign ch      = addr[4:2];
    assign reg_off = {addr[1:0], 2'b00};
    assign hit     = rcn_in[RCN_VALID] & rcn_in[RCN_PEND] & (addr[21:5] == ADDR_BASE[23:7]);
    assign we      = hit & wr;
    assign ch_ok   = int'(ch) < NUM_CH;

    // Channels beyond NUM_CH are padded with zero registers so reads of them return 0
    // and writes have no instance to land in.
    for (genvar c = 0; c < 8; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            rcn_testregs_ch u_ch (
                .clk         (clk),
                .rst_n       (rst_n),
                .we_progress (we & ch == 3'(c) & reg_off == OFF_PROGRESS),
                .we_fail     (we & ch == 3'(c) & reg_off == OFF_FAIL),
                .we_pass     (we & ch == 3'(c) & reg_off == OFF_PASS),
                .mask        (mask),
                .wdata       (wdata),
                .progress    (prog8[c]),
                .fail        (fail8[c]),
                .pass        (pass8[c]),
                .done        (done8[c])
            );
            assign test_progress[32*c +: 32] = prog8[c];
            assign test_fail[32*c +: 32]     = fail8[c];
            assign test_pass[32*c +: 32]     = pass8[c];
            assign test_done[c]              = done8[c];
        end else begin : g_off
            assign prog8[c] = '0;
            assign fail8[c] = '0;
            assign pass8[c] = '0;
            assign done8[c] = 1'b0;
        end
    end

    always_comb
        rdata = !ch_ok                  ? '0 :
                reg_off == OFF_PROGRESS ? prog8[ch] :
                reg_off == OFF_FAIL     ? fail8[ch] :
                reg_off == OFF_PASS     ? pass8[ch] :
                                          {29'b0, timeout, done8[ch], armed};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rcn_out <= '0;
        else rcn_out <= hit ? {1'b1, 1'b0, rcn_in[RCN_WR:RCN_SEQ_LSB], wr ? wdata : rdata} : rcn_in;

`ifdef RCN_TESTREGS_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt, wdog_cnt_d;
    logic armed_d, timeout_d, prog_wr, clr;

    assign prog_wr = we & ch_ok & reg_off == OFF_PROGRESS;
    assign clr     = we & ch == 3'd0 & reg_off == OFF_STATUS & wdata[2];

    // Timeout is raised in the same edge the counter reaches all-ones; clear beats expiry.
    always_comb begin
        wdog_cnt_d = clr | prog_wr ? '0 : armed & ~&wdog_cnt ? wdog_cnt + WDOG_W'(1) : wdog_cnt;
        armed_d    = ~clr & (armed | prog_wr);
        timeout_d  = ~clr & (timeout | (armed_d & &wdog_cnt_d));
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wdog_cnt <= '0;
            armed    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            wdog_cnt <= wdog_cnt_d;
            armed    <= armed_d;
            timeout  <= timeout_d;
        end
`else
    logic wdog_unused;
    assign armed       = 1'b0;
    assign timeout     = 1'b0;
    assign wdog_unused = WDOG_W[0];
`endif

    assign test_timeout = timeout;
endmodule
